// File: rtl/frame_pkg.sv
// frame_pkg: state encoding, default framing words and a width helper shared
// by the frame deframer files.
package frame_pkg;

  localparam logic [15:0] DEF_HDR_WORD  = 16'hE0E0;
  localparam logic [15:0] DEF_TAIL_WORD = 16'h0E0E;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    CHAN,
    BODY,
    TAIL,
    CHECK,
    CRC_REQ,
    WRITE,
    DROP
  } state_t;

  // Bits needed to hold a count from 0 up to max_words inclusive.
  function automatic int len_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/frame_deframer_p_if.sv
// frame_deframer_p_if: CRC request/response and FIFO write bus of the deframer.
// The master side is the deframer; the slave side is the CRC engine plus FIFO.
interface frame_deframer_p_if
  import frame_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 8,
  parameter int CH_W      = 8,
  parameter int LEN_W     = len_width(MAX_WORDS)
) ();

  logic [MAX_WORDS*DATA_W-1:0]            crc_data;
  logic [LEN_W-1:0]                       crc_len;
  logic                                   crc_valid;
  logic                                   crc_ready;
  logic [DATA_W-1:0]                      crc_result;
  logic [LEN_W+MAX_WORDS*DATA_W+CH_W-1:0] fifo_wdata;
  logic                                   fifo_w_enable;
  logic                                   fifo_full;

  modport master (
    output crc_data, crc_len, crc_valid, fifo_wdata, fifo_w_enable,
    input  crc_ready, crc_result, fifo_full
  );

  modport slave (
    input  crc_data, crc_len, crc_valid, fifo_wdata, fifo_w_enable,
    output crc_ready, crc_result, fifo_full
  );

endinterface

// File: rtl/frame_body_buf.sv
// frame_body_buf: collects body words of one frame (payload plus trailing CRC
// word) in a shift buffer, newest word at index 0, and presents the payload
// left-aligned with the oldest word in the MSBs.
module frame_body_buf
  import frame_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              MAX_WORDS = 8,
  parameter logic [DATA_W-1:0] TAIL_WORD = DEF_TAIL_WORD,
  parameter int              LEN_W     = len_width(MAX_WORDS)
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push_one,
  input  logic                        push_two,
  input  logic [DATA_W-1:0]           din,
  output logic                        full_one,
  output logic                        full_two,
  output logic [MAX_WORDS*DATA_W-1:0] payload,
  output logic [DATA_W-1:0]           crc_word,
  output logic [LEN_W-1:0]            payload_len
);

  localparam int DEPTH = MAX_WORDS + 1;
  localparam int CNT_W = len_width(DEPTH);

  logic [DATA_W-1:0] words [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  idx;

  // No room for one more word, or for a held tail plus the word after it.
  assign full_one = (count >= CNT_W'(DEPTH));
  assign full_two = (count >= CNT_W'(DEPTH - 1));

  assign crc_word    = (count == '0) ? '0 : words[0];
  assign payload_len = (count == '0) ? '0 : LEN_W'(count - CNT_W'(1));

  // Shift buffer and word count; a push that would overflow is refused.
  always_ff @(posedge clk_in) begin
    if (!rst_n || clear) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (push_one && !full_one) begin
      words[0] <= din;
      for (int i = 1; i < DEPTH; i++) words[i] <= words[i-1];
      count <= count + CNT_W'(1);
    end else if (push_two && !full_two) begin
      words[0] <= din;
      words[1] <= TAIL_WORD;
      for (int i = 2; i < DEPTH; i++) words[i] <= words[i-2];
      count <= count + CNT_W'(2);
    end
  end

  // Left-align payload words (everything except the newest, the CRC), zero-fill.
  always_comb begin
    payload = '0;
    idx     = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (CNT_W'(k + 1) < count) begin
        idx = count - CNT_W'(k + 1);
        payload[(MAX_WORDS-1-k)*DATA_W +: DATA_W] = words[idx];
      end
    end
  end

endmodule

// File: rtl/frame_deframer_p.sv
// frame_deframer_p: parses HDR HDR CH BODY... CRC TAIL TAIL frames, asks the
// external CRC engine to verify the payload and writes good frames to a FIFO.
module frame_deframer_p
  import frame_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                MAX_WORDS = 8,
  parameter int                CH_W      = 8,
  parameter logic [DATA_W-1:0] HDR_WORD  = DEF_HDR_WORD,
  parameter logic [DATA_W-1:0] TAIL_WORD = DEF_TAIL_WORD,
  parameter int                LEN_W     = len_width(MAX_WORDS)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  frame_deframer_p_if.master  bus,
  output logic                crc_err,
  output logic                len_err,
  output logic [15:0]         crc_err_cnt
);

  state_t state, state_nx;

  logic [CH_W-1:0]             channel;
  logic                        drop_tail, drop_tail_nx;
  logic                        buf_clear, push_one, push_two;
  logic                        full_one, full_two;
  logic                        load_channel, load_crc, load_fifo;
  logic                        crc_err_nx, len_err_nx;
  logic [MAX_WORDS*DATA_W-1:0] payload;
  logic [DATA_W-1:0]           crc_word;
  logic [LEN_W-1:0]            payload_len;

  frame_body_buf #(
    .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .TAIL_WORD(TAIL_WORD), .LEN_W(LEN_W)
  ) u_body_buf (
    .clk_in(clk_in), .rst_n(rst_n), .clear(buf_clear),
    .push_one(push_one), .push_two(push_two), .din(din),
    .full_one(full_one), .full_two(full_two), .payload(payload),
    .crc_word(crc_word), .payload_len(payload_len)
  );

  // The write strobe is qualified by fifo_full in the same cycle so a write
  // can never land on a full FIFO.
  assign bus.crc_valid     = (state == CRC_REQ);
  assign bus.fifo_w_enable = (state == WRITE) && !bus.fifo_full;

  // Next-state and control strobes; words are only consumed when din_valid.
  always_comb begin
    state_nx     = state;
    drop_tail_nx = drop_tail;
    buf_clear    = 1'b0;
    push_one     = 1'b0;
    push_two     = 1'b0;
    load_channel = 1'b0;
    load_crc     = 1'b0;
    load_fifo    = 1'b0;
    crc_err_nx   = 1'b0;
    len_err_nx   = 1'b0;
    case (state)
      IDLE: if (din_valid && din == HDR_WORD) state_nx = HDR;
      HDR: if (din_valid) state_nx = (din == HDR_WORD) ? CHAN : IDLE;
      CHAN: if (din_valid) begin
        load_channel = 1'b1;
        buf_clear    = 1'b1;
        state_nx     = BODY;
      end
      BODY: if (din_valid) begin
        if (din == TAIL_WORD) begin
          state_nx = TAIL;
        end else if (full_one) begin
          len_err_nx   = 1'b1;
          drop_tail_nx = 1'b0;
          state_nx     = DROP;
        end else begin
          push_one = 1'b1;
        end
      end
      TAIL: if (din_valid) begin
        if (din == TAIL_WORD) begin
          state_nx = CHECK;
        end else if (full_two) begin
          len_err_nx   = 1'b1;
          drop_tail_nx = 1'b0;
          state_nx     = DROP;
        end else begin
          push_two = 1'b1;
          state_nx = BODY;
        end
      end
      CHECK: begin
        if (payload_len == '0) begin
          len_err_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          load_crc = 1'b1;
          state_nx = CRC_REQ;
        end
      end
      CRC_REQ: if (bus.crc_ready) begin
        if (bus.crc_result == crc_word) begin
          load_fifo = 1'b1;
          state_nx  = WRITE;
        end else begin
          crc_err_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      WRITE: if (!bus.fifo_full) state_nx = IDLE;
      DROP: if (din_valid) begin
        if (din == TAIL_WORD) begin
          drop_tail_nx = 1'b1;
          if (drop_tail) begin
            drop_tail_nx = 1'b0;
            state_nx     = IDLE;
          end
        end else begin
          drop_tail_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, latched frame fields, registered outputs and the error counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state          <= IDLE;
      drop_tail      <= 1'b0;
      channel        <= '0;
      crc_err        <= 1'b0;
      len_err        <= 1'b0;
      crc_err_cnt    <= '0;
      bus.crc_data   <= '0;
      bus.crc_len    <= '0;
      bus.fifo_wdata <= '0;
    end else begin
      state     <= state_nx;
      drop_tail <= drop_tail_nx;
      crc_err   <= crc_err_nx;
      len_err   <= len_err_nx;
      if (load_channel) channel <= din[CH_W-1:0];
      if (load_crc) begin
        bus.crc_data <= payload;
        bus.crc_len  <= payload_len;
      end
      if (load_fifo) bus.fifo_wdata <= {bus.crc_len, bus.crc_data, channel};
      if (crc_err_nx && crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
    end
  end

endmodule
